// File: rtl/tns_enc_seq_31.sv
// -----------------------------------------------------------------------------
// tns_enc_seq_31
// Sequential TNS encoder for the 31-wire CAC bus (transmit-side counterpart of
// the 31-wire TNS decoder). A binary word is converted into a 31-bit TNS
// codeword by greedy MSB-first subtraction, one weight per clock.
//
// Weight map (bit 30 down to bit 0):
//   TNS11_C, TNS10_A, TNS10_B, TNS10_C, TNS09_A ... TNS01_A, TNS01_B, TNS01_C
// The set is Fibonacci-type: W[0]=1, W[1]=2, W[i]=W[i-1]+W[i-2]. Every weight
// is at most one more than the sum of all lower weights, so greedy encoding
// covers every value from 0 up to the weight sum (5702885) with no remainder.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   datain is valid
//   in_ready   out  1   encoder can accept a word this cycle
//   datain     in   DW  binary word to encode
//   out_valid  out  1   codeout/code_err valid
//   out_ready  in   1   sink accepts codeout this cycle
//   codeout    out  CW  TNS codeword, bit i carries weight W[i]
//   code_err   out  1   datain not representable (remainder left after bit 0)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a word, in_ready=1
// RUN   | one weight per cycle, idx 30 down to 0
// DONE  | codeword presented, held until out_ready; may reload same cycle
// -----------------------------------------------------------------------------
module tns_enc_seq_31 #(
  parameter int DW = 23,
  parameter int CW = 31
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] datain,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] codeout,
  output logic          code_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [DW-1:0] rem;
  logic [4:0]    idx;
  logic [DW-1:0] w_cur;
  logic          take;
  logic [DW-1:0] rem_next;
  logic          accept;

  function automatic logic [DW-1:0] tns_weight(input logic [4:0] i);
    logic [DW-1:0] w;
    case (i)
      5'd0:  w = DW'(1);
      5'd1:  w = DW'(2);
      5'd2:  w = DW'(3);
      5'd3:  w = DW'(5);
      5'd4:  w = DW'(8);
      5'd5:  w = DW'(13);
      5'd6:  w = DW'(21);
      5'd7:  w = DW'(34);
      5'd8:  w = DW'(55);
      5'd9:  w = DW'(89);
      5'd10: w = DW'(144);
      5'd11: w = DW'(233);
      5'd12: w = DW'(377);
      5'd13: w = DW'(610);
      5'd14: w = DW'(987);
      5'd15: w = DW'(1597);
      5'd16: w = DW'(2584);
      5'd17: w = DW'(4181);
      5'd18: w = DW'(6765);
      5'd19: w = DW'(10946);
      5'd20: w = DW'(17711);
      5'd21: w = DW'(28657);
      5'd22: w = DW'(46368);
      5'd23: w = DW'(75025);
      5'd24: w = DW'(121393);
      5'd25: w = DW'(196418);
      5'd26: w = DW'(317811);
      5'd27: w = DW'(514229);
      5'd28: w = DW'(832040);
      5'd29: w = DW'(1346269);
      5'd30: w = DW'(2178309);
      default: w = '0;
    endcase
    return w;
  endfunction

  assign w_cur    = tns_weight(idx);
  assign take     = (rem >= w_cur);
  assign rem_next = take ? (rem - w_cur) : rem;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (idx == 5'd0) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Ready passes straight through so a new word can load on the
        // same edge the finished codeword leaves.
        in_ready  = out_ready;
        if (out_ready) state_next = in_valid ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
    // The state register already reads IDLE during reset; hold off the source.
    if (!rst_n) in_ready = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      idx      <= 5'd30;
      codeout  <= '0;
      code_err <= 1'b0;
    end else begin
      if (accept) begin
        rem      <= datain;
        idx      <= 5'd30;
        codeout  <= '0;
        code_err <= 1'b0;
      end else if (state == RUN) begin
        rem <= rem_next;
        if (take) codeout[idx] <= 1'b1;
        if (idx == 5'd0) begin
          code_err <= (rem_next != '0);
        end else begin
          idx <= idx - 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tns_enc_seq_31.sv
`timescale 1ns/1ps
module tb_tns_enc_seq_31;
  localparam int DW = 23;
  localparam int CW = 31;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] datain;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] codeout;
  logic          code_err;

  int errors = 0;
  int checks = 0;

  longint wt [0:30];
  longint wsum;

  tns_enc_seq_31 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .datain    (datain),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .codeout   (codeout),
    .code_err  (code_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: greedy encoding straight from the numeral-system definition.
  function automatic logic [CW-1:0] ref_code(input longint d);
    logic [CW-1:0] c;
    longint r;
    c = '0;
    r = d;
    for (int i = 30; i >= 0; i--) begin
      if (r >= wt[i]) begin
        c[i] = 1'b1;
        r = r - wt[i];
      end
    end
    return c;
  endfunction

  function automatic logic ref_err(input longint d);
    longint r;
    r = d;
    for (int i = 30; i >= 0; i--) if (r >= wt[i]) r = r - wt[i];
    return (r != 0);
  endfunction

  function automatic longint decode(input logic [CW-1:0] c);
    longint s;
    s = 0;
    for (int i = 0; i < CW; i++) if (c[i]) s = s + wt[i];
    return s;
  endfunction

  task automatic send(input logic [DW-1:0] d);
    int n;
    datain   = d;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) chk("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_word(input logic [DW-1:0] d, input string tag);
    int lat;
    out_ready = 1'b1;
    send(d);
    wait_out(lat);
    chk({tag, "_latency"}, lat, 31);
    chk({tag, "_code"}, codeout, ref_code(longint'(d)));
    chk({tag, "_err"}, code_err, ref_err(longint'(d)));
    if (longint'(d) <= wsum) chk({tag, "_loopback"}, decode(codeout), d);
    @(posedge clk);
    #1 chk({tag, "_released"}, out_valid, 1'b0);
  endtask

  initial begin
    int lat;
    logic [CW-1:0] hold;
    logic [DW-1:0] seq [0:7];
    int n_in, n_out, last_t;
    logic acc, xfer;

    wt[0] = 1;
    wt[1] = 2;
    for (int i = 2; i < 31; i++) wt[i] = wt[i-1] + wt[i-2];
    wsum = 0;
    for (int i = 0; i < 31; i++) wsum = wsum + wt[i];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    datain    = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_codeout", codeout, '0);
    chk("rst_code_err", code_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b1);

    // Directed corner words.
    run_word('0, "zero");
    chk("zero_exact", codeout, 31'h0);
    run_word(DW'(wt[30]), "top");
    chk("top_exact", codeout, 31'h4000_0000);
    run_word(DW'(wt[30] + wt[0]), "top_plus1");
    chk("top_plus1_exact", codeout, 31'h4000_0001);
    run_word(DW'(wsum), "wsum");
    chk("wsum_err", code_err, 1'b0);
    run_word({DW{1'b1}}, "all_ones");
    chk("all_ones_err", code_err, 1'b1);

    // Back-pressure: codeword must hold while the sink stalls.
    out_ready = 1'b0;
    send(DW'(23'h1234AB));
    wait_out(lat);
    chk("bp_latency", lat, 31);
    hold = codeout;
    chk("bp_code", codeout, ref_code(longint'(23'h1234AB)));
    datain   = DW'(23'h00BEEF);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_hold", codeout, hold);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp_reload_out_valid", out_valid, 1'b0);
    wait_out(lat);
    chk("bp2_latency", lat, 31);
    chk("bp2_code", codeout, ref_code(longint'(23'h00BEEF)));
    @(posedge clk);
    #1;

    // Back-to-back stream with in_valid held high.
    for (int i = 0; i < 8; i++) seq[i] = DW'($urandom_range(0, 32'd5702885));
    n_in = 0;
    n_out = 0;
    last_t = -1;
    out_ready = 1'b1;
    datain = seq[0];
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 8 * 32 + 100; cyc++) begin
      @(negedge clk);
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer) begin
        chk("b2b_code", codeout, ref_code(longint'(seq[n_out])));
        if (n_out > 0) chk("b2b_interval", cyc - last_t, 32);
        last_t = cyc;
        n_out++;
      end
      if (acc) n_in++;
      @(posedge clk);
      #1;
      if (acc) begin
        if (n_in < 8) datain = seq[n_in];
        else in_valid = 1'b0;
      end
      if (n_out == 8) break;
    end
    in_valid = 1'b0;
    chk("b2b_count", n_out, 8);
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of an encode at idx 15.
    send(DW'(23'h7ABCDE & 23'h3FFFFF));
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_codeout", codeout, '0);
    chk("midrst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_no_output", out_valid, 1'b0);
    run_word(DW'(5), "after_rst");
    chk("after_rst_exact", codeout, 31'h0000_0008);

    // Random in-range words with loopback decode.
    for (int i = 0; i < 600; i++) begin
      run_word(DW'($urandom_range(0, 32'd5702885)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
